// File: rtl/cpu_pkg.sv
// Shared core package: instruction widths, NOP encoding, fetch FSM states and
// the opcode constants consumed by the main control decoder.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int OPC_W   = 6;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [OPC_W-1:0] OPC_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OPC_J     = 6'h02;
  localparam logic [OPC_W-1:0] OPC_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_BNE   = 6'h05;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[INSTR_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an instruction word and its pc+4 while the
// IF/ID register is stalled. Clear wins over load, load wins over drain.
module fetch_skid
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc4   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc4   <= load_pc4;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake, redirect handling and the
// IF/ID register. Define FETCH_PERF_EN to add the perf_fetched/perf_stall counters.
//
// Handshake: imem_req is held with a stable imem_addr until imem_ack; a cycle with
// imem_req && imem_ack completes the transfer and imem_rdata is sampled that cycle.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc4,
  output logic [OPC_W-1:0]   if_opcode,
  output fetch_state_e       dbg_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d;
  logic [ADDR_W-1:0] pc_plus4, redirect_tgt;
  logic              if_block, accept_mem, if_load;
  logic              skid_load, skid_drain, skid_clear;
  logic              skid_valid;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc4;

  assign pc_plus4     = pc_q + ADDR_W'(4);
  assign redirect_tgt = redirect_pc & ALIGN_MASK;
  assign if_block     = if_valid && stall;

  // Gating with rst keeps the request low throughout reset and lets it rise in
  // the very first cycle after release.
  assign imem_req  = !rst && (state_q != HOLD);
  assign imem_addr = pc_q;
  assign if_opcode = opcode_of(if_instr);
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    tgt_d      = tgt_q;
    accept_mem = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_d = redirect_tgt;
          end else if (if_block) begin
            skid_load = 1'b1;
            pc_d      = pc_plus4;
            state_d   = HOLD;
          end else begin
            accept_mem = 1'b1;
            pc_d       = pc_plus4;
          end
        end else if (redirect_valid) begin
          // Request stays outstanding on the old address; target waits in tgt_q.
          tgt_d   = redirect_tgt;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          skid_clear = 1'b1;
          pc_d       = redirect_tgt;
          state_d    = FETCH;
        end else if (!stall) begin
          skid_drain = 1'b1;
          state_d    = FETCH;
        end
      end
      DROP: begin
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_tgt : tgt_q;
          state_d = FETCH;
        end else if (redirect_valid) begin
          tgt_d = redirect_tgt;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC & ALIGN_MASK;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  fetch_skid #(.ADDR_W(ADDR_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (skid_clear),
    .load_instr (imem_rdata),
    .load_pc4   (pc_plus4),
    .valid      (skid_valid),
    .instr      (skid_instr),
    .pc4        (skid_pc4)
  );

  assign if_load = !redirect_valid && !if_block &&
                   (accept_mem || (skid_drain && skid_valid));

  // Redirect flush beats a stall hold, which beats a load or bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc4   <= '0;
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (if_block) begin
      if_valid <= 1'b1;
    end else if (accept_mem) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc4   <= pc_plus4;
    end else if (skid_drain && skid_valid) begin
      if_valid <= 1'b1;
      if_instr <= skid_instr;
      if_pc4   <= skid_pc4;
    end else begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (if_load)  perf_fetched <= perf_fetched + 32'd1;
      if (if_block) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a combinational memory whose data is
// the fetch address XOR 32'h8C00_0000 (an lw opcode for low addresses).
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int ADDR_W = 32;

  logic               clk;
  logic               rst;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [31:0]        imem_rdata;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               if_valid;
  logic [31:0]        if_instr;
  logic [ADDR_W-1:0]  if_pc4;
  logic [5:0]         if_opcode;
  fetch_state_e       dbg_state;
`ifdef FETCH_PERF_EN
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_stall;
`endif

  logic               ack_en;
  int                 n_checks;
  int                 n_pass;
  logic [31:0]        exp_q[$];

  fetch_stage #(.ADDR_W(ADDR_W), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc4         (if_pc4),
    .if_opcode      (if_opcode),
    .dbg_state      (dbg_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  // Clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req && ack_en;
  assign imem_rdata = imem_ack ? (imem_addr ^ 32'h8C00_0000) : 32'hDEAD_BEEF;

  // Driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_pc4_q(input string tag);
    logic [31:0] e;
    e = exp_q.pop_front();
    chk(tag, if_pc4, e);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ack_en = 1'b1;

    // Reset values
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc4",   if_pc4, 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(FETCH));
    step(); step();

    // Zero-wait streaming from reset
    rst = 1'b0;
    #1;
    chk("c1_req",  32'(imem_req), 32'd1);
    chk("c1_addr", imem_addr, 32'h0);
    exp_q.push_back(32'd4); exp_q.push_back(32'd8); exp_q.push_back(32'd12);
    step();
    chk("c2_valid",  32'(if_valid), 32'd1);
    chk_pc4_q("c2_pc4");
    chk("c2_instr",  if_instr, 32'h8C00_0000);
    chk("c2_opcode", 32'(if_opcode), 32'(OPC_LW));
    step();
    chk_pc4_q("c3_pc4");

    // Stall three cycles with IF/ID holding the word from 4
    stall = 1'b1;
    step();
    chk("st1_pc4",   if_pc4, 32'd8);
    chk("st1_req",   32'(imem_req), 32'd0);
    chk("st1_state", 32'(dbg_state), 32'(HOLD));
    chk("st1_valid", 32'(if_valid), 32'd1);
    step();
    chk("st2_pc4", if_pc4, 32'd8);
    chk("st2_req", 32'(imem_req), 32'd0);
    step();
    stall = 1'b0;
    chk("st3_pc4", if_pc4, 32'd8);
    step();
    chk_pc4_q("rel_pc4");
    chk("rel_state", 32'(dbg_state), 32'(FETCH));
    chk("rel_addr",  imem_addr, 32'd12);
    step();
    chk("rel2_pc4",   if_pc4, 32'd16);
    chk("rel2_instr", if_instr, 32'h8C00_000C);

    // Redirect while a request waits three cycles
    ack_en = 1'b0; stall = 1'b1;
    step();
    chk("ws_addr", imem_addr, 32'd16);
    chk("ws_pc4",  if_pc4, 32'd16);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("drop_state", 32'(dbg_state), 32'(DROP));
    chk("drop_addr",  imem_addr, 32'd16);
    chk("drop_req",   32'(imem_req), 32'd1);
    chk("drop_valid", 32'(if_valid), 32'd0);
    chk("drop_instr", if_instr, 32'h0);
    step();
    ack_en = 1'b1;
    chk("drop2_addr", imem_addr, 32'd16);
    step();
    stall = 1'b0;
    chk("redir_state", 32'(dbg_state), 32'(FETCH));
    chk("redir_addr",  imem_addr, 32'h40);
    chk("redir_valid", 32'(if_valid), 32'd0);
    step();
    chk("redir_pc4",   if_pc4, 32'h44);
    chk("redir_instr", if_instr, 32'h8C00_0040);

    // Redirect and ack together under stall; low target bits masked
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    stall = 1'b0; redirect_valid = 1'b0;
    chk("same_addr",  imem_addr, 32'h100);
    chk("same_valid", 32'(if_valid), 32'd0);
    chk("same_instr", if_instr, 32'h0);
    step();
    chk("same_pc4", if_pc4, 32'h104);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc4",    if_pc4, 32'h0);
    chk("wrap_instr",  if_instr, 32'h73FF_FFFC);
    chk("wrap_opcode", 32'(if_opcode), 32'h1C);
    chk("wrap_next",   imem_addr, 32'h0);
    step();
    chk("wrap2_pc4", if_pc4, 32'h4);

    // Asynchronous reset during an outstanding request
    ack_en = 1'b0;
    chk("pre_rst_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_req",   32'(imem_req), 32'd0);
    chk("ar_addr",  imem_addr, 32'h0);
    chk("ar_valid", 32'(if_valid), 32'd0);
    chk("ar_instr", if_instr, 32'h0);
    chk("ar_pc4",   if_pc4, 32'h0);
    chk("ar_state", 32'(dbg_state), 32'(FETCH));
    step();
    ack_en = 1'b1; rst = 1'b0;
    #1;
    chk("ar_rel_req",  32'(imem_req), 32'd1);
    chk("ar_rel_addr", imem_addr, 32'h0);
    step();
    chk("ar_rel_pc4", if_pc4, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
